// File: rtl/lsu_bus_if_pkg.sv
// Shared types for the load/store bus interface: access-size encodings,
// FSM states and the natural-alignment rule.
package lsu_bus_if_pkg;

    localparam int XLEN   = 64;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        MEMOP_B     = 3'b000,
        MEMOP_H     = 3'b001,
        MEMOP_W     = 3'b010,
        MEMOP_D     = 3'b011,
        MEMOP_BU    = 3'b100,
        MEMOP_HU    = 3'b101,
        MEMOP_WU    = 3'b110,
        MEMOP_D_ALT = 3'b111
    } memop_e;

    // state | meaning
    // IDLE  | no access in flight, accepting core requests
    // REQ   | bus_req_valid asserted, payload held until ready
    // WAIT  | request accepted, waiting for the response pulse
    // DONE  | stall released for one cycle so the core commits
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic memop_aligned(input memop_e op, input logic [2:0] off);
        case (op)
            MEMOP_B, MEMOP_BU: return 1'b1;
            MEMOP_H, MEMOP_HU: return ~off[0];
            MEMOP_W, MEMOP_WU: return (off[1:0] == 2'b00);
            default:           return (off == 3'b000);
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store data/strobe placement and load extract/extend.
module lsu_align
    import lsu_bus_if_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        st_off,
    input  memop_e            st_op,
    input  logic [XLEN-1:0]   st_data,
    output logic [XLEN-1:0]   lane_wdata,
    output logic [XLEN/8-1:0] lane_wstrb,
    input  logic [2:0]        ld_off,
    input  memop_e            ld_op,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   ld_data
);

    localparam int SW = XLEN / 8;

    logic [XLEN-1:0] rd_shift;

    always_comb begin
        lane_wdata = st_data << {st_off, 3'b000};
        lane_wstrb = '0;
        case (st_op)
            MEMOP_B, MEMOP_BU: lane_wstrb = SW'(1)  << st_off;
            MEMOP_H, MEMOP_HU: lane_wstrb = SW'(3)  << st_off;
            MEMOP_W, MEMOP_WU: lane_wstrb = SW'(15) << st_off;
            default:           lane_wstrb = '1;
        endcase
    end

    always_comb begin
        rd_shift = rdata >> {ld_off, 3'b000};
        ld_data  = rd_shift;
        case (ld_op)
            MEMOP_B:  ld_data = {{(XLEN-8){rd_shift[7]}},   rd_shift[7:0]};
            MEMOP_H:  ld_data = {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            MEMOP_W:  ld_data = {{(XLEN-32){rd_shift[31]}}, rd_shift[31:0]};
            MEMOP_BU: ld_data = {{(XLEN-8){1'b0}},          rd_shift[7:0]};
            MEMOP_HU: ld_data = {{(XLEN-16){1'b0}},         rd_shift[15:0]};
            MEMOP_WU: ld_data = {{(XLEN-32){1'b0}},         rd_shift[31:0]};
            default:  ld_data = rd_shift;
        endcase
    end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store unit: turns core data-memory accesses into valid/ready bus
// transactions and stalls the core until each one completes.
module lsu_bus_if
    import lsu_bus_if_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_ld,
    input  logic              core_st,
    input  logic [XLEN-1:0]   core_addr,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic [2:0]        core_memop,
    output logic [XLEN-1:0]   core_rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_wstrb,
    input  logic              bus_rsp_valid,
    input  logic [XLEN-1:0]   bus_rdata
);

    lsu_state_e        state;
    memop_e            op_q;
    logic [2:0]        off_q;
    logic              mis_hold;
    logic              req;
    logic              aligned;
    logic              misaligned_now;
    memop_e            core_op;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN/8-1:0] lane_wstrb;
    logic [XLEN-1:0]   ld_data;
    logic              unused_addr_hi;

    assign core_op        = memop_e'(core_memop);
    assign req            = core_ld | core_st;
    assign aligned        = memop_aligned(core_op, core_addr[2:0]);
    assign misaligned_now = (state == ST_IDLE) & req & ~aligned;
    assign stall          = req & (state != ST_DONE) & ~misaligned_now;
    assign unused_addr_hi = ^core_addr[XLEN-1:ADDR_W];

    lsu_align #(.XLEN(XLEN)) u_align (
        .st_off     (core_addr[2:0]),
        .st_op      (core_op),
        .st_data    (core_wdata),
        .lane_wdata (lane_wdata),
        .lane_wstrb (lane_wstrb),
        .ld_off     (off_q),
        .ld_op      (op_q),
        .rdata      (bus_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            op_q          <= MEMOP_B;
            off_q         <= '0;
            mis_hold      <= 1'b0;
            misalign      <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_wstrb     <= '0;
            core_rdata    <= '0;
        end else begin
            // mis_hold suppresses a repeat pulse while the core keeps presenting the same bad access
            misalign <= misaligned_now & ~mis_hold;
            mis_hold <= misaligned_now;
            case (state)
                ST_IDLE: begin
                    if (req && aligned) begin
                        bus_req_valid <= 1'b1;
                        bus_we        <= core_st;
                        bus_addr      <= {core_addr[ADDR_W-1:3], 3'b000};
                        bus_wdata     <= core_st ? lane_wdata : '0;
                        bus_wstrb     <= core_st ? lane_wstrb : '0;
                        op_q          <= core_op;
                        off_q         <= core_addr[2:0];
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_rsp_valid) begin
                        if (!bus_we) core_rdata <= ld_data;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_bus_if.md
Name: lsu_bus_if

Overview:
- Load/store unit directly downstream of the single-cycle core's data-memory port.
- Takes the core's DmemAddr/DmemDataI/MemWr/MemOp plus a load-request flag, runs a valid/ready transaction on a 64-bit data bus, and returns aligned, extended load data as DmemDataO.
- Stalls the core (PC and regfile write hold) while a transaction is outstanding.

Parameters:
- XLEN, 64, data/address width; bus data width equals XLEN.
- ADDR_W, 32, bus address width; low ADDR_W bits of the core address are used.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- core_ld  in  1  load request this cycle (core RegWrSel path).
- core_st  in  1  store request this cycle (core MemWr).
- core_addr  in  XLEN  byte address (DmemAddr).
- core_wdata  in  XLEN  store data, low-aligned (DmemDataI).
- core_memop  in  3  access size/sign (MemOp).
- core_rdata  out  XLEN  extended load data (DmemDataO).
- stall  out  1  core must hold PC, instr and all core_* inputs.
- misalign  out  1  one-cycle pulse: misaligned access dropped.
- bus_req_valid  out  1  request valid.
- bus_req_ready  in  1  request accepted when valid&ready.
- bus_addr  out  ADDR_W  doubleword-aligned address, bits [2:0]=0.
- bus_we  out  1  1=write.
- bus_wdata  out  XLEN  lane-shifted write data.
- bus_wstrb  out  XLEN/8  byte enables.
- bus_rsp_valid  in  1  read data / write ack, one-cycle pulse.
- bus_rdata  in  XLEN  read doubleword.

Behaviour:
- MemOp encoding: 000 B, 001 H, 010 W, 011 D (signed), 100 BU, 101 HU, 110 WU; 111 treated as D.
- Reset: state IDLE; bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, core_rdata=0, misalign=0. stall=0 in IDLE with no request.
- stall = (core_ld|core_st) & (state!=DONE) & ~misaligned_now. It is combinational, so it rises in the same cycle as the request.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
  - IDLE, request present and aligned: latch addr, op, we, lane data and strobes. Go to REQ. A request with both core_ld and core_st set is treated as a store.
  - REQ: bus_req_valid=1 with registered payload. Payload is stable until valid&ready. On handshake go to WAIT.
  - WAIT: on bus_rsp_valid, register the extracted load data into core_rdata (stores leave it unchanged). Go to DONE. bus_rsp_valid in REQ or IDLE is ignored.
  - DONE: stall=0 for exactly one cycle; core commits; return to IDLE.
- Minimum latency is 3 cycles (request cycle, REQ, WAIT with immediate rsp), then DONE. Back-to-back accesses restart from IDLE on the next cycle.
- Alignment: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - A misaligned request in IDLE pulses misalign for 1 cycle and stalls 0.
  - No bus transaction occurs.
  - The FSM stays in IDLE. misalign is registered, so the pulse appears on the cycle after the request. It does not re-pulse while the same request is held.
- Store lanes: off=addr[2:0].
  - wdata = core_wdata << (8*off).
  - wstrb: B = 1<<off; H = 3<<off; W = 0xF<<off; D = 0xFF.
- Load extract: d = bus_rdata >> (8*off), then truncate to the size. Sign-extend for B/H/W/D; zero-extend for BU/HU/WU.
- Reset mid-transaction: asynchronous return to IDLE with all outputs at reset values. A pending bus response is discarded.

Decomposition:
- Shared package/defines: MemOp encodings (MEMOP_B..MEMOP_WU), FSM state encodings, XLEN (already in defines).
- One sub-module: lsu_align, purely combinational. It performs the strobe/wdata lane shift and the load extract/extend.

Test Plan:
- LD at 0x80001000 with rsp data 0x1122334455667788 and ready/rsp immediate -> stall high 3 cycles, core_rdata=0x1122334455667788 in DONE.
- LB at 0x80001007 with rdata 0x80xx...xx -> core_rdata=0xFFFFFFFFFFFFFF80. LBU at the same address -> 0x0000000000000080.
- SH 0xBEEF at 0x80001002 -> bus_wstrb=0x0C, bus_wdata[31:16]=0xBEEF, bus_we=1, bus_addr=0x80001000.
- bus_req_ready held low 5 cycles -> bus_req_valid and payload stable, stall high throughout; completes after ready and rsp.
- LW at 0x80001006 -> misalign pulse one cycle later, bus_req_valid never asserted, stall=0.
- rst_n low while in WAIT, then a late bus_rsp_valid -> outputs at reset values, response ignored, next LD completes normally.
